// File: rtl/jtframe_serjoy.sv
// Serial joystick reader for chained 74HC165-style pads on the user port.
// Scans PLAYERS*BITS buttons through joy_load/joy_clk/joy_data and publishes them on joys.
module jtframe_serjoy #(
  parameter int unsigned PLAYERS = 2,
  parameter int unsigned BITS    = 12,
  parameter int unsigned CLKDIV  = 8,
  parameter int unsigned GAP     = 64,
  parameter int unsigned INVERT  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [PLAYERS-1:0]        player_mask,
  input  logic                      joy_data,
  output logic                      joy_clk,
  output logic                      joy_load,
  output logic [PLAYERS*BITS-1:0]   joys,
  output logic                      joy_vld,
  output logic                      busy
);

  localparam int unsigned N  = PLAYERS * BITS;
  localparam int unsigned BW = $clog2(N + 1);

  localparam logic [7:0]    DivLast = 8'(CLKDIV - 1);
  localparam logic [7:0]    GapLast = 8'((GAP == 0) ? 0 : GAP - 1);
  localparam logic [BW-1:0] BitLast = BW'(N - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StLow,
    StHigh,
    StDone,
    StGap
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      phase_q, phase_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [N-1:0]    raw_q, raw_d;
  logic [N-1:0]    joys_q, joys_d;
  logic [1:0]      sync_q;
  logic            sd;
  logic            vld_d, vld_q;
  logic            joy_clk_q, joy_load_q, busy_q;
  logic            phase_last;
  logic [N-1:0]    mask_vec;
  logic [N-1:0]    raw_pol;

  assign sd = sync_q[1];

  always_comb begin
    mask_vec = '0;
    for (int unsigned p = 0; p < PLAYERS; p++) begin
      mask_vec[p*BITS +: BITS] = {BITS{player_mask[p]}};
    end
  end

  assign raw_pol    = (INVERT != 0) ? ~raw_q : raw_q;
  assign phase_last = (phase_q == DivLast);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    raw_d   = raw_q;
    joys_d  = joys_q;
    vld_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        phase_d = '0;
        bit_d   = '0;
        if (enable) state_d = StLoad;
      end
      StLoad: begin
        if (phase_last) begin
          state_d = StLow;
          phase_d = '0;
          bit_d   = '0;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      StLow: begin
        if (phase_last) begin
          // Last LOW cycle gives the chain the most settling time before sampling
          for (int unsigned i = 0; i < N; i++) begin
            if (bit_q == BW'(i)) raw_d[i] = sd;
          end
          state_d = StHigh;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      StHigh: begin
        if (phase_last) begin
          phase_d = '0;
          if (bit_q == BitLast) begin
            state_d = StDone;
          end else begin
            bit_d   = bit_q + BW'(1);
            state_d = StLow;
          end
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      StDone: begin
        joys_d  = raw_pol & mask_vec;
        vld_d   = 1'b1;
        phase_d = '0;
        state_d = (GAP == 0) ? StLoad : StGap;
      end
      StGap: begin
        if (phase_q == GapLast) begin
          state_d = StLoad;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        phase_d = '0;
        bit_d   = '0;
      end
    endcase

    // Disable aborts any scan in progress; a partial scan is never published
    if (!enable) begin
      state_d = StIdle;
      phase_d = '0;
      bit_d   = '0;
      joys_d  = '0;
      vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      phase_q    <= '0;
      bit_q      <= '0;
      raw_q      <= '0;
      joys_q     <= '0;
      sync_q     <= '0;
      vld_q      <= 1'b0;
      joy_clk_q  <= 1'b0;
      joy_load_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      raw_q      <= raw_d;
      joys_q     <= joys_d;
      sync_q     <= {sync_q[0], joy_data};
      vld_q      <= vld_d;
      // Pin levels are registered from the next state so they line up with it glitch-free
      joy_clk_q  <= (state_d == StHigh);
      joy_load_q <= (state_d != StLoad);
      busy_q     <= (state_d == StLoad) || (state_d == StLow) ||
                    (state_d == StHigh) || (state_d == StDone);
    end
  end

  assign joy_clk  = joy_clk_q;
  assign joy_load = joy_load_q;
  assign joys     = joys_q;
  assign joy_vld  = vld_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_jtframe_serjoy.sv
// Directed bench for jtframe_serjoy: two configurations, each driven by a 74HC165 chain model.
module tb_jtframe_serjoy;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Config A: 2 pads x 8 bits, CLKDIV 4, GAP 16, active-low pads
  logic        enable_a;
  logic [1:0]  mask_a;
  logic        joy_data_a, joy_clk_a, joy_load_a, joy_vld_a, busy_a;
  logic [15:0] joys_a;
  logic [15:0] lvl_a;
  logic [15:0] sr_a = '1;
  logic        jc_prev_a = 1'b0;

  jtframe_serjoy #(
    .PLAYERS(2), .BITS(8), .CLKDIV(4), .GAP(16), .INVERT(1)
  ) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable_a),
    .player_mask(mask_a),
    .joy_data   (joy_data_a),
    .joy_clk    (joy_clk_a),
    .joy_load   (joy_load_a),
    .joys       (joys_a),
    .joy_vld    (joy_vld_a),
    .busy       (busy_a)
  );

  always @(posedge clk) begin
    if (!joy_load_a) sr_a <= lvl_a;
    else if (joy_clk_a && !jc_prev_a) sr_a <= {1'b1, sr_a[15:1]};
    jc_prev_a <= joy_clk_a;
  end
  assign joy_data_a = sr_a[0];

  // Config B: 1 pad x 12 bits, CLKDIV 3, no gap, active-high pads
  logic        enable_b;
  logic [0:0]  mask_b;
  logic        joy_data_b, joy_clk_b, joy_load_b, joy_vld_b, busy_b;
  logic [11:0] joys_b;
  logic [11:0] lvl_b;
  logic [11:0] sr_b = '0;
  logic        jc_prev_b = 1'b0;

  jtframe_serjoy #(
    .PLAYERS(1), .BITS(12), .CLKDIV(3), .GAP(0), .INVERT(0)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable_b),
    .player_mask(mask_b),
    .joy_data   (joy_data_b),
    .joy_clk    (joy_clk_b),
    .joy_load   (joy_load_b),
    .joys       (joys_b),
    .joy_vld    (joy_vld_b),
    .busy       (busy_b)
  );

  always @(posedge clk) begin
    if (!joy_load_b) sr_b <= lvl_b;
    else if (joy_clk_b && !jc_prev_b) sr_b <= {1'b0, sr_b[11:1]};
    jc_prev_b <= joy_clk_b;
  end
  assign joy_data_b = sr_b[0];

  task automatic wait_vld_a(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!joy_vld_a && n < limit);
    if (!joy_vld_a) check_eq("vld_a_timeout", {31'd0, joy_vld_a}, 32'd1);
  endtask

  task automatic wait_vld_b(input int limit, output int n, output int busy_low);
    n = 0;
    busy_low = 0;
    do begin
      @(negedge clk);
      n++;
      if (!busy_b) busy_low++;
    end while (!joy_vld_b && n < limit);
    if (!joy_vld_b) check_eq("vld_b_timeout", {31'd0, joy_vld_b}, 32'd1);
  endtask

  task automatic check_reset_a(input string pfx);
    check_eq({pfx, "_clk"},  {31'd0, joy_clk_a},  32'd0);
    check_eq({pfx, "_load"}, {31'd0, joy_load_a}, 32'd1);
    check_eq({pfx, "_joys"}, {16'd0, joys_a},     32'd0);
    check_eq({pfx, "_vld"},  {31'd0, joy_vld_a},  32'd0);
    check_eq({pfx, "_busy"}, {31'd0, busy_a},     32'd0);
  endtask

  initial begin
    int n, bad, vcnt, busy_low;
    int load_lo, busy_n, rises, hi_n, vld_n, vld_at;
    logic prev_clk;
    logic [15:0] joys_at;

    rst_n    = 1'b0;
    enable_a = 1'b0;
    enable_b = 1'b0;
    mask_a   = 2'b11;
    mask_b   = 1'b1;
    lvl_a    = ~16'h3C5A;
    lvl_b    = 12'hA53;
    repeat (2) @(negedge clk);
    check_reset_a("rst");
    rst_n = 1'b1;

    // First scan: waveform shape and bit mapping
    @(negedge clk);
    enable_a = 1'b1;
    @(negedge clk);
    check_eq("load_start", {31'd0, joy_load_a}, 32'd0);
    load_lo = 0; busy_n = 0; rises = 0; hi_n = 0; vld_n = 0; vld_at = -1;
    prev_clk = 1'b0; joys_at = '0;
    for (int i = 0; i < 149; i++) begin
      if (!joy_load_a) load_lo++;
      if (busy_a) busy_n++;
      if (joy_clk_a) hi_n++;
      if (joy_clk_a && !prev_clk) rises++;
      prev_clk = joy_clk_a;
      if (joy_vld_a) begin
        vld_n++;
        if (vld_at < 0) begin
          vld_at  = i;
          joys_at = joys_a;
        end
      end
      @(negedge clk);
    end
    check_eq("load_width",  load_lo, 32'd4);
    check_eq("busy_width",  busy_n,  32'd133);
    check_eq("clk_pulses",  rises,   32'd16);
    check_eq("clk_high",    hi_n,    32'd64);
    check_eq("vld_width",   vld_n,   32'd1);
    check_eq("vld_latency", vld_at,  32'd133);
    check_eq("bit_map",     {16'd0, joys_at}, 32'h3C5A);
    check_eq("next_load",   {31'd0, joy_load_a}, 32'd0);
    wait_vld_a(400, n);
    check_eq("vld_period",  149 + n - vld_at, 32'd149);
    check_eq("bit_map2",    {16'd0, joys_a}, 32'h3C5A);

    // Mask: only pad 0 reported, then a mid-scan mask change lands at the next strobe
    lvl_a  = 16'h0000;
    mask_a = 2'b01;
    wait_vld_a(400, n);
    wait_vld_a(400, n);
    check_eq("mask_01", {16'd0, joys_a}, 32'h00FF);
    repeat (40) @(negedge clk);
    mask_a = 2'b11;
    bad = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!joy_vld_a && joys_a !== 16'h00FF) bad++;
    end while (!joy_vld_a && n < 400);
    check_eq("mask_hold", bad, 32'd0);
    check_eq("mask_11",   {16'd0, joys_a}, 32'hFFFF);

    // Abort at bit 9, then restart from LOAD
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (joy_load_a && n < 400);
    check_eq("abort_scan_start", {31'd0, joy_load_a}, 32'd0);
    repeat (78) @(negedge clk);
    check_eq("abort_in_low", {31'd0, joy_clk_a}, 32'd0);
    enable_a = 1'b0;
    @(negedge clk);
    check_eq("abort_clk",  {31'd0, joy_clk_a},  32'd0);
    check_eq("abort_load", {31'd0, joy_load_a}, 32'd1);
    check_eq("abort_joys", {16'd0, joys_a},     32'd0);
    check_eq("abort_busy", {31'd0, busy_a},     32'd0);
    vcnt = 0;
    bad  = 0;
    repeat (20) begin
      @(negedge clk);
      if (joy_vld_a) vcnt++;
      if (joys_a !== 16'h0) bad++;
    end
    check_eq("abort_no_vld", vcnt, 32'd0);
    check_eq("abort_joys0",  bad,  32'd0);
    enable_a = 1'b1;
    @(negedge clk);
    check_eq("restart_load", {31'd0, joy_load_a}, 32'd0);
    wait_vld_a(400, n);
    check_eq("restart_lat",  n, 32'd133);
    check_eq("restart_joys", {16'd0, joys_a}, 32'hFFFF);

    // Asynchronous reset while joy_clk is high
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!joy_clk_a && n < 400);
    check_eq("rst_in_high", {31'd0, joy_clk_a}, 32'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_a("arst");
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rel_idle", {31'd0, joy_load_a}, 32'd1);
    @(negedge clk);
    check_eq("rel_load", {31'd0, joy_load_a}, 32'd0);

    // Config B: no inversion, no gap between scans
    enable_a = 1'b0;
    enable_b = 1'b1;
    wait_vld_b(400, n, busy_low);
    check_eq("b_data",   {20'd0, joys_b}, 32'hA53);
    check_eq("b_no_gap", {31'd0, joy_load_b}, 32'd0);
    wait_vld_b(400, n, busy_low);
    check_eq("b_period",   n,        32'd76);
    check_eq("b_busy_low", busy_low, 32'd0);
    check_eq("b_data2",    {20'd0, joys_b}, 32'hA53);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
